// File: rtl/seg_scan_mux.sv
// Multi-digit 7-segment scan driver with frame-coherent shadow, load/ack handshake and ghost blanking.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_mux #(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned DIV         = 50000,
    parameter int unsigned BLANK       = 16,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          AN_ACT_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   hex_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     dig_en,
    input  logic                  load,
    output logic                  load_ack,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK);
    localparam logic [7:0]        SEG_OFF = {8{SEG_ACT_LOW}};
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACT_LOW}};

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [4*DIGITS-1:0]   r_pend_hex;
    logic [DIGITS-1:0]     r_pend_dp;
    logic [DIGITS-1:0]     r_pend_en;
    logic                  r_pend_flag;
    logic [4*DIGITS-1:0]   r_sh_hex;
    logic [DIGITS-1:0]     r_sh_dp;
    logic [DIGITS-1:0]     r_sh_en;
    logic [7:0]            r_seg;
    logic [DIGITS-1:0]     r_an;
    logic                  r_load_ack;
    logic                  r_frame_done;

    logic                  w_boundary;
    logic                  w_show;
    logic [3:0]            w_nib;
    logic [7:0]            w_seg_on;
    logic [DIGITS-1:0]     w_an_on;

    // High-active a..g pattern for one hex nibble
    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h7E;
            4'h1: pat = 7'h30;
            4'h2: pat = 7'h6D;
            4'h3: pat = 7'h79;
            4'h4: pat = 7'h33;
            4'h5: pat = 7'h5B;
            4'h6: pat = 7'h5F;
            4'h7: pat = 7'h70;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h7B;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h1F;
            4'hC: pat = 7'h4E;
            4'hD: pat = 7'h3D;
            4'hE: pat = 7'h4F;
            default: pat = 7'h47;
        endcase
        return pat;
    endfunction

    assign w_boundary = (r_presc == PRESC_MAX) && (r_idx == IDX_MAX);

    // Slot prescaler and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (r_presc == PRESC_MAX) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Pending register and frame-boundary transfer into the display shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_hex  <= '0;
            r_pend_dp   <= '0;
            r_pend_en   <= '0;
            r_pend_flag <= 1'b0;
            r_sh_hex    <= '0;
            r_sh_dp     <= '0;
            r_sh_en     <= '0;
        end else begin
            if (w_boundary && r_pend_flag) begin
                r_sh_hex    <= r_pend_hex;
                r_sh_dp     <= r_pend_dp;
                r_sh_en     <= r_pend_en;
                r_pend_flag <= 1'b0;
            end
            // A load on the transfer cycle wins: data stays pending for the next frame
            if (load) begin
                r_pend_hex  <= hex_in;
                r_pend_dp   <= dp_in;
                r_pend_en   <= dig_en;
                r_pend_flag <= 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    logic [DIGITS-1:0] w_lzb;

    // Digit i>0 blanks when it and all higher nibbles are zero and its dp is off
    always_comb begin
        logic w_zero_above;
        w_zero_above = 1'b1;
        w_lzb        = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above && (r_sh_hex[4*i +: 4] == 4'h0);
            w_lzb[i]     = w_zero_above && !r_sh_dp[i];
        end
    end
`endif

    // Active-high segment/anode pattern for the current counter state
    always_comb begin
        w_seg_on = '0;
        w_an_on  = '0;
        w_nib    = r_sh_hex[{r_idx, 2'b00} +: 4];
        w_show   = (r_presc >= BLANK_END) && r_sh_en[r_idx];
`ifdef SEG_SCAN_LZB_EN
        if (w_lzb[r_idx]) begin
            w_show = 1'b0;
        end
`endif
        if (w_show) begin
            w_an_on[r_idx] = 1'b1;
            w_seg_on       = {f_decode(w_nib), r_sh_dp[r_idx]};
        end
    end

    // Output registers; polarity applied last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= SEG_OFF;
            r_an         <= AN_OFF;
            r_load_ack   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg_on ^ SEG_OFF;
            r_an         <= w_an_on ^ AN_OFF;
            r_load_ack   <= w_boundary && r_pend_flag;
            r_frame_done <= w_boundary;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign load_ack   = r_load_ack;
    assign frame_done = r_frame_done;

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Parametrised multi-digit 7-segment display driver.
- Holds a frame-coherent snapshot of DIGITS hex nibbles plus decimal points, and time-multiplexes them onto one shared segment bus with per-digit anode selects.
- Adds inter-digit ghost blanking, a load/ack handshake and configurable pin polarity.
- Sits between CPU-visible display registers and the board's 7-segment pins.

Parameters:
- DIGITS, 8: number of digits; legal 1..16.
- DIV, 50000: clk cycles per digit slot; legal >=2.
- BLANK, 16: cycles at the start of each slot with all outputs inactive; legal 0..DIV-1.
- SEG_ACT_LOW, 1: 1 = segment pins active-low (inverted at output).
- AN_ACT_LOW, 1: 1 = anode pins active-low.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- hex_in  in  4*DIGITS  nibble i = hex_in[4i+3:4i] for digit i (digit 0 is rightmost).
- dp_in  in  DIGITS  decimal point per digit.
- dig_en  in  DIGITS  per-digit enable.
- load  in  1  capture hex_in/dp_in/dig_en into the pending register.
- load_ack  out  1  one-cycle pulse when pending data moves to the display shadow.
- seg  out  8  {a,b,c,d,e,f,g,dp}, a = bit7; polarity per SEG_ACT_LOW.
- an  out  DIGITS  digit select; polarity per AN_ACT_LOW.
- frame_done  out  1  one-cycle pulse after the last slot of each frame.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset state: all counters 0; pending = 0; pend_flag = 0; shadow = 0 (including shadow dig_en). Outputs: an all inactive, seg all inactive, load_ack = 0, frame_done = 0. Display stays dark until the first load has been applied.
- presc counts 0..DIV-1 and wraps. idx ($clog2(DIGITS) bits, minimum 1) increments when presc==DIV-1 and wraps from DIGITS-1 to 0.
- Frame boundary cycle: presc==DIV-1 && idx==DIGITS-1.
- frame_done: registered, high the cycle after each boundary.
- load: on any cycle, pending <= {hex_in, dp_in, dig_en} and pend_flag <= 1. A second load before the boundary overwrites pending; no queue.
- Transfer on a boundary cycle with pend_flag=1:
  - shadow <= pending value held before this cycle;
  - load_ack pulses the next cycle;
  - pend_flag <= 0, unless load is also high that cycle. In that case the new data enters pending, pend_flag stays 1, and it is applied at the following boundary.
- Decode, high-active a..g:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70;
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
  - 8-bit seg = {abcdefg, dp}.
- Output registers, 1-cycle latency from counter state:
  - presc<BLANK: an and seg all inactive.
  - Otherwise, if shadow dig_en[idx]=1: an[idx] active, all other anodes inactive, seg = decode(shadow nibble idx) with dp = shadow dp[idx].
  - Otherwise (digit disabled): an all inactive, seg inactive.
- Polarity inversion is applied last. Polarity parameters never change timing.
- Reset mid-operation: outputs go inactive immediately (asynchronously). Any pending load is discarded. Scanning restarts at idx 0, presc 0.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined: digit i>0 is additionally blanked (an inactive, seg inactive) when shadow nibble i and every higher-index nibble are 0 and shadow dp[i]=0. Digit 0 is never blanked by this rule. Evaluated on shadow data, so blanking is frame-coherent.
- Undefined: every enabled digit is displayed, including leading zeros.

Test Plan:
- All tests use DIGITS=4, DIV=8, BLANK=2, both polarities active-low.
- Reset: hold rst_n=0, then release -> an=4'b1111, seg=8'hFF, load_ack=0. frame_done first pulses 32 cycles after release. Display stays dark.
- Load basic: load hex_in=16'h12AF, dp_in=0, dig_en=4'hF -> load_ack one cycle after the next boundary. In slot 0: 2 cycles an=1111, then 6 cycles an=1110 with seg=~8'b10001110=8'h71. Slot 3 shows '1': an=0111, seg=8'h9F.
- Overwrite: two loads in one frame (16'h1111, then 16'h2222) -> only 2222 displayed; exactly one load_ack.
- Coincident load: load 16'h0005 mid-frame, then load 16'h0006 on the boundary cycle -> 5 applied with ack; 6 applied at the next boundary with a second ack; acks are 32 cycles apart.
- Async reset mid-slot: pull rst_n low while an=1101 -> an=1111 and seg=FF before the next clk edge. After release, the pending load is lost, with no ack.
- SEG_SCAN_LZB_EN defined, load hex_in=16'h0030, dp_in=0, dig_en=F -> digits 3 and 2 stay dark, digit 1 shows seg=~8'hF2, digit 0 shows '0' (~8'hFC). Without the macro, all four digits light.
